// File: rtl/param_nx1_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : param_nx1_arb_mux
// Purpose  : Registered, parametrised N-to-1 word multiplexer with
//            valid/ready handshakes on every input channel and on the output.
//            This is the general form of the 4-bit 2x1 select mux that feeds
//            the adder-subtractor input stage.
//            Mode 0 : manual, the external Select picks the channel.
//            Mode 1 : round-robin, fair arbitration among valid channels.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     data word width in bits (>=1)
//   CHANNELS  number of input channels (>=2)
//   SEL_W     channel index width, derived as $clog2(CHANNELS)
// Ports
//   Clk        in   1               rising-edge clock
//   Reset      in   1               synchronous active-high reset
//   In_Data    in   CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   In_Valid   in   CHANNELS        per-channel word valid
//   In_Ready   out  CHANNELS        per-channel accept (combinational)
//   In_Last    in   CHANNELS        end-of-packet flag (ARB_MUX_LOCK_EN only)
//   Mode       in   1               0 = manual Select, 1 = round-robin
//   Select     in   SEL_W           channel index used in manual mode
//   Out        out  WIDTH           registered output word
//   Out_Valid  out  1               Out holds an unconsumed word
//   Out_Ready  in   1               downstream accepts Out this cycle
//   Out_Chan   out  SEL_W           channel that supplied Out
// Configuration
//   ARB_MUX_LOCK_EN : when defined, adds In_Last and locks the round-robin
//                     grant to a channel until its packet ends.
// ============================================================================
module param_nx1_arb_mux #(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 2,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [CHANNELS*WIDTH-1:0] In_Data,
   input  logic [CHANNELS-1:0]       In_Valid,
   output logic [CHANNELS-1:0]       In_Ready,
`ifdef ARB_MUX_LOCK_EN
   input  logic [CHANNELS-1:0]       In_Last,
`endif
   input  logic                      Mode,
   input  logic [SEL_W-1:0]          Select,
   output logic [WIDTH-1:0]          Out,
   output logic                      Out_Valid,
   input  logic                      Out_Ready,
   output logic [SEL_W-1:0]          Out_Chan
);

   // Channel count and last index expressed in index-arithmetic widths.
   // SEL_W+1 bits hold CHANNELS and any sum of two valid indices.
   localparam logic [SEL_W:0]   c_NUM_CH  = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(CHANNELS-1);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0]    out_q,       out_d;
   logic                out_valid_q, out_valid_d;
   logic [SEL_W-1:0]    chan_q,      chan_d;
   logic [SEL_W-1:0]    ptr_q,       ptr_d;

   // -------------------------------------------------------------------------
   // Combinational
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0]    w_word [CHANNELS];
   logic                w_load_en;
   logic [CHANNELS-1:0] w_lock_mask;
   logic [CHANNELS-1:0] w_req;
   logic [CHANNELS-1:0] w_rot;
   logic [SEL_W:0]      w_sum;
   logic                w_any;
   logic [SEL_W-1:0]    w_idx;
   logic [CHANNELS-1:0] w_grant;
   logic [WIDTH-1:0]    w_data;
   logic                w_xfer;

   // Unpack the flat data bus into one word per channel.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_word
         assign w_word[gi] = In_Data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // The single output register may load when empty or when it is being
   // drained this very cycle, which gives full throughput.
   assign w_load_en = !out_valid_q || Out_Ready;

`ifdef ARB_MUX_LOCK_EN
   // -------------------------------------------------------------------------
   // Packet lock: after a non-final word from channel k transfers in
   // round-robin mode, only channel k may be granted until its last word.
   // -------------------------------------------------------------------------
   logic                lock_q,      lock_d;
   logic [SEL_W-1:0]    lock_chan_q, lock_chan_d;
   logic                w_last_sel;

   assign w_lock_mask = lock_q ? (CHANNELS'(1) << lock_chan_q) : '1;
   assign w_last_sel  = |(In_Last & w_grant);

   // Any cycle spent in manual mode drops the lock, so a mode change always
   // enters round-robin unlocked.
   always_comb begin
      lock_d      = lock_q;
      lock_chan_d = lock_chan_q;
      if (!Mode) begin
         lock_d = 1'b0;
      end else if (w_xfer) begin
         lock_d      = !w_last_sel;
         lock_chan_d = w_idx;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lock_q      <= 1'b0;
         lock_chan_q <= '0;
      end else begin
         lock_q      <= lock_d;
         lock_chan_q <= lock_chan_d;
      end
   end
`else
   assign w_lock_mask = '1;
`endif

   // -------------------------------------------------------------------------
   // Grant selection. Produces at most one winner (w_any / w_idx).
   // -------------------------------------------------------------------------
   always_comb begin
      w_req = '0;
      w_rot = '0;
      w_sum = '0;
      w_any = 1'b0;
      w_idx = '0;
      if (!Mode) begin
         // An out-of-range Select matches no channel, so nothing is granted.
         for (int i = 0; i < CHANNELS; i++) begin
            if (Select == SEL_W'(i) && In_Valid[i]) begin
               w_any = 1'b1;
               w_idx = Select;
            end
         end
      end else begin
         w_req = In_Valid & w_lock_mask;
         // Rotate right by the pointer so bit 0 is the highest-priority slot.
         w_rot = (w_req >> ptr_q) | (w_req << (c_NUM_CH - {1'b0, ptr_q}));
         // Descending scan: the lowest set offset is written last and wins.
         for (int off = CHANNELS - 1; off >= 0; off--) begin
            if (w_rot[off]) begin
               w_any = 1'b1;
               w_sum = {1'b0, ptr_q} + (SEL_W+1)'(off);
            end
         end
         if (w_sum >= c_NUM_CH) begin
            w_sum = w_sum - c_NUM_CH;
         end
         w_idx = w_sum[SEL_W-1:0];
      end
   end

   // One-hot grant vector and data selection from the winning index.
   always_comb begin
      w_grant = '0;
      w_data  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_any && w_idx == SEL_W'(i)) begin
            w_grant[i] = 1'b1;
            w_data     = w_word[i];
         end
      end
   end

   // Ready is suppressed during reset so no word is lost into a register
   // that is being cleared.
   assign In_Ready = (w_load_en && !Reset) ? w_grant : '0;
   assign w_xfer   = w_load_en && w_any && !Reset;

   // -------------------------------------------------------------------------
   // Output register and round-robin pointer next state.
   // -------------------------------------------------------------------------
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      chan_d      = chan_q;
      ptr_d       = ptr_q;
      if (w_load_en) begin
         // Draining without reload clears valid but keeps data and channel.
         out_valid_d = w_xfer;
         if (w_xfer) begin
            out_d  = w_data;
            chan_d = w_idx;
         end
      end
      // Manual transfers leave the pointer alone so switching back to
      // round-robin resumes where it left off.
      if (w_xfer && Mode) begin
         ptr_d = (w_idx == c_LAST_CH) ? '0 : w_idx + SEL_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         chan_q      <= '0;
         ptr_q       <= '0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         chan_q      <= chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign Out       = out_q;
   assign Out_Valid = out_valid_q;
   assign Out_Chan  = chan_q;

endmodule
`default_nettype wire
